// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: fetch sequencer state encoding and the
// system-instruction encodings the decoder matches to raise halt_instr.
package rv32_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    MEM   = 3'd2,
    HALT  = 3'd3,
    ERROR = 3'd4
  } fetch_state_t;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

  function automatic logic is_halt_instr(input logic [31:0] word);
    return (word == INSTR_EBREAK) || (word == INSTR_ECALL);
  endfunction

endpackage

// File: rtl/fetch_sequencer_ack_timer.sv
// Acknowledge wait timer for fetch_sequencer: counts idle request cycles and
// flags the last permitted cycle before a timeout fault.
module ack_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic terminal
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign terminal = (count_reg == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute/memory cadence controller driving imem/dmem requests and the PC
// enable. Define FETCH_SEQUENCER_TIMEOUT_EN to enable the acknowledge timeout fault.
module fetch_sequencer
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        dmem_access,
  input  logic        dmem_ack,
  input  logic        halt_instr,
  input  logic        resume,
  output logic        imem_req,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        dmem_req,
  output logic        pc_en,
  output logic        halted,
  output logic        fetch_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("fetch_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  fetch_state_t state_reg, state_next;
  logic [31:0]  instr_reg;
  logic         load_instr;
  // Set after the first HALT cycle so a resume held high on entry is not taken.
  logic         halt_armed_reg;

`ifdef FETCH_SEQUENCER_TIMEOUT_EN
  logic timer_clear;
  logic timer_count;
  logic timeout;

  assign timer_clear = (state_next != state_reg);
  assign timer_count = ((state_reg == FETCH) && !imem_ack) ||
                       ((state_reg == MEM) && !dmem_ack);

  ack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ack_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clear),
    .count_en (timer_count),
    .terminal (timeout)
  );
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= FETCH;
      instr_reg      <= '0;
      halt_armed_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      halt_armed_reg <= (state_reg == HALT);
      if (load_instr) begin
        instr_reg <= imem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_en      = 1'b0;
    load_instr = 1'b0;
    case (state_reg)
      FETCH: begin
        if (imem_ack) begin
          load_instr = 1'b1;
          state_next = EXEC;
        end
`ifdef FETCH_SEQUENCER_TIMEOUT_EN
        else if (timeout) begin
          state_next = ERROR;
        end
`endif
      end
      EXEC: begin
        if (halt_instr) begin
          state_next = HALT;
        end else if (dmem_access) begin
          state_next = MEM;
        end else begin
          pc_en      = 1'b1;
          state_next = FETCH;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          pc_en      = 1'b1;
          state_next = FETCH;
        end
`ifdef FETCH_SEQUENCER_TIMEOUT_EN
        else if (timeout) begin
          state_next = ERROR;
        end
`endif
      end
      HALT: begin
        if (resume && halt_armed_reg) begin
          pc_en      = 1'b1;
          state_next = FETCH;
        end
      end
`ifdef FETCH_SEQUENCER_TIMEOUT_EN
      ERROR: begin
        state_next = ERROR;
      end
`endif
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign imem_req    = (state_reg == FETCH);
  assign dmem_req    = (state_reg == MEM);
  assign instr_valid = (state_reg == EXEC) || (state_reg == MEM) || (state_reg == HALT);
  assign halted      = (state_reg == HALT);
  assign instr_out   = instr_reg;

`ifdef FETCH_SEQUENCER_TIMEOUT_EN
  assign fetch_err = (state_reg == ERROR);
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// instruction streams checked against a phase-level model of the cadence.
module tb_fetch_sequencer;
  import rv32_pkg::*;

`ifdef FETCH_SEQUENCER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clock;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_access;
  logic        dmem_ack;
  logic        halt_instr;
  logic        resume;
  logic        imem_req;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        dmem_req;
  logic        pc_en;
  logic        halted;
  logic        fetch_err;

  fetch_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .dmem_access (dmem_access),
    .dmem_ack    (dmem_ack),
    .halt_instr  (halt_instr),
    .resume      (resume),
    .imem_req    (imem_req),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .dmem_req    (dmem_req),
    .pc_en       (pc_en),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          cycles = 0;
  int          pc_pulses = 0;
  int          dreq_cycles = 0;
  int          retired = 0;
  logic [31:0] ref_instr = '0;

  // Output vector order: {imem_req, instr_valid, dmem_req, pc_en, halted, fetch_err}
  task automatic check_outs(input logic [5:0] exp, input string tag);
    logic [5:0] obs;
    obs = {imem_req, instr_valid, dmem_req, pc_en, halted, fetch_err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s outs observed=%b expected=%b", tag, obs, exp);
    end
    checks++;
    assert (instr_out === ref_instr) else begin
      errors++;
      $error("FAIL %s instr_out observed=%h expected=%h", tag, instr_out, ref_instr);
    end
  endtask

  task automatic check_int(input int obs, input int exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven; sample at negedge, then advance.
  task automatic step(input logic [5:0] exp, input string tag);
    @(negedge clock);
    check_outs(exp, tag);
    if (pc_en === 1'b1) pc_pulses++;
    if (dmem_req === 1'b1) dreq_cycles++;
    @(posedge clock);
    #1;
    cycles++;
  endtask

  task automatic noise();
    imem_ack    = 1'($urandom);
    imem_rdata  = $urandom;
    dmem_ack    = 1'($urandom);
    resume      = 1'($urandom);
    halt_instr  = 1'($urandom);
    dmem_access = 1'($urandom);
  endtask

  // Assert reset asynchronously mid-cycle and check outputs before any edge.
  task automatic apply_reset(input string tag);
    #2 reset = 1'b0;
    ref_instr = '0;
    #1;
    check_outs(6'b100000, tag);
    @(posedge clock);
    #1;
    check_outs(6'b100000, tag);
    reset = 1'b1;
  endtask

  // One instruction: fw wait cycles before imem_ack, mw before dmem_ack,
  // hw cycles after HALT entry until resume; early holds resume high on entry.
  task automatic run_instr(input int fw, input logic [31:0] rd, input bit mem,
                           input int mw, input int hw, input bit early);
    bit hlt;
    hlt = is_halt_instr(rd);
    for (int i = 0; i <= fw; i++) begin
      noise();
      imem_ack = (i == fw);
      if (i == fw) imem_rdata = rd;
      step(6'b100000, "fetch");
    end
    ref_instr = rd;
    noise();
    halt_instr  = hlt;
    dmem_access = mem;
    if (early) resume = 1'b1;
    step({1'b0, 1'b1, 1'b0, (!hlt && !mem), 1'b0, 1'b0}, "exec");
    if (!hlt && !mem) retired++;
    if (hlt) begin
      noise();
      resume = early;
      step(6'b010010, "halt_entry");
      for (int j = 1; j <= hw; j++) begin
        noise();
        resume = (j == hw);
        step({1'b0, 1'b1, 1'b0, (j == hw), 1'b1, 1'b0}, "halt");
      end
      retired++;
    end else if (mem) begin
      for (int j = 0; j <= mw; j++) begin
        noise();
        dmem_ack = (j == mw);
        step({1'b0, 1'b1, 1'b1, (j == mw), 1'b0, 1'b0}, "mem");
      end
      retired++;
    end
  endtask

  initial begin
    int c0, p0, d0, r0;
    logic [31:0] rd;
    reset = 1'b1;
    imem_ack = 0; imem_rdata = 0; dmem_access = 0; dmem_ack = 0;
    halt_instr = 0; resume = 0;
    @(posedge clock);
    #1;
    apply_reset("reset");

    // Constant ack, plain instructions: 2 cycles per instruction.
    c0 = cycles; p0 = pc_pulses;
    for (int k = 0; k < 10; k++) run_instr(0, 32'h0000_0013 + k, 1'b0, 0, 1, 1'b0);
    check_int(cycles - c0, 20, "plain10_cycles");
    check_int(pc_pulses - p0, 10, "plain10_pcen");

    // Ack on third FETCH cycle.
    p0 = pc_pulses;
    run_instr(2, 32'h00A0_0093, 1'b0, 0, 1, 1'b0);
    check_int(pc_pulses - p0, 1, "addi_pcen");

    // Load/store with dmem_ack on the 4th MEM cycle.
    d0 = dreq_cycles; p0 = pc_pulses;
    run_instr(0, 32'h0000_2083, 1'b1, 3, 1, 1'b0);
    check_int(dreq_cycles - d0, 4, "mem_dreq_cycles");
    check_int(pc_pulses - p0, 1, "mem_pcen");

    // Halt beats dmem_access; resume 5 cycles later; then a halt with early resume.
    d0 = dreq_cycles;
    run_instr(0, INSTR_EBREAK, 1'b1, 0, 5, 1'b0);
    check_int(dreq_cycles - d0, 0, "halt_no_dreq");
    run_instr(1, INSTR_ECALL, 1'b0, 0, 2, 1'b1);
    run_instr(0, 32'h0000_0033, 1'b0, 0, 1, 1'b0);

    // Reset during MEM with dmem_ack high: request abandoned, no pc_en.
    p0 = pc_pulses;
    noise(); imem_ack = 1'b1; imem_rdata = 32'h0040_2103;
    step(6'b100000, "rst_fetch");
    ref_instr = 32'h0040_2103;
    noise(); halt_instr = 1'b0; dmem_access = 1'b1;
    step(6'b010000, "rst_exec");
    noise(); dmem_ack = 1'b0;
    step(6'b011000, "rst_mem");
    dmem_ack = 1'b1;
    apply_reset("reset_in_mem");
    check_int(pc_pulses - p0, 0, "reset_mem_pcen");
    run_instr(0, 32'h0000_0013, 1'b0, 0, 1, 1'b0);

`ifdef FETCH_SEQUENCER_TIMEOUT_EN
    // Ack in the terminal cycle still wins.
    run_instr(TO - 1, 32'h0000_0093, 1'b1, TO - 1, 1, 1'b0);
    // No ack: ERROR after TO FETCH cycles, sticky, ignores all inputs.
    p0 = pc_pulses;
    for (int i = 0; i < TO; i++) begin
      noise(); imem_ack = 1'b0;
      step(6'b100000, "to_fetch");
    end
    for (int i = 0; i < 4; i++) begin
      noise(); imem_ack = 1'b1; dmem_ack = 1'b1; resume = 1'b1;
      step(6'b000001, "to_error");
    end
    check_int(pc_pulses - p0, 0, "to_pcen");
    apply_reset("reset_from_error");
    // Timeout during MEM.
    noise(); imem_ack = 1'b1; imem_rdata = 32'h0000_a003;
    step(6'b100000, "tom_fetch");
    ref_instr = 32'h0000_a003;
    noise(); halt_instr = 1'b0; dmem_access = 1'b1;
    step(6'b010000, "tom_exec");
    for (int i = 0; i < TO; i++) begin
      noise(); dmem_ack = 1'b0;
      step(6'b011000, "tom_mem");
    end
    noise();
    step(6'b000001, "tom_error");
    apply_reset("reset_from_mem_error");
`endif

    // Randomized instruction stream.
    r0 = retired; p0 = pc_pulses;
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 3) rd = ($urandom_range(0, 1) == 1) ? INSTR_EBREAK : INSTR_ECALL;
      else rd = $urandom;
      run_instr(int'($urandom_range(0, 2)), rd, (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1),
                int'($urandom_range(0, 2)), int'($urandom_range(1, 4)), 1'($urandom));
    end
    check_int(pc_pulses - p0, retired - r0, "random_pcen");
    check_int(pc_pulses, retired, "total_pcen");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction sequencer that drives the PC enable (`in_en`) and the instruction/data memory request lines. It requests an instruction and latches it on acknowledge. It then holds the instruction valid while execution and any data-memory access complete, and only then advances the PC. It sits between the memory bus and the `pc` block, and gives the core a stall-safe fetch/execute/memory cadence plus a halt/resume mechanism.

## Interface
- `TIMEOUT_CYCLES`, 16: cycles to wait for an acknowledge before faulting; only used with `FETCH_SEQUENCER_TIMEOUT_EN`; minimum 2.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `imem_ack` in 1: instruction memory acknowledge; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `dmem_access` in 1: decoder flag; the current instruction is a load or store.
- `dmem_ack` in 1: data memory acknowledge.
- `halt_instr` in 1: decoder flag; the current instruction is EBREAK/ECALL.
- `resume` in 1: external debug resume request.
- `imem_req` out 1: instruction fetch request.
- `instr_out` out 32: latched instruction.
- `instr_valid` out 1: `instr_out` is the instruction currently executing.
- `dmem_req` out 1: data memory request.
- `pc_en` out 1: single-cycle pulse to the PC `in_en`.
- `halted` out 1: core halted.
- `fetch_err` out 1: acknowledge timeout fault, sticky.

## Operation
States: FETCH, EXEC, MEM, HALT, ERROR. ERROR exists only with the macro.

- **FETCH**
  - `imem_req`=1.
  - On `imem_ack`: `instr_out`<=`imem_rdata`, go to EXEC.
- **EXEC**
  - `instr_valid`=1. Decoder flags are sampled this cycle.
  - Priority is `halt_instr` > `dmem_access` > normal.
  - `halt_instr`: go to HALT, `pc_en`=0.
  - `dmem_access`: go to MEM, `pc_en`=0.
  - Otherwise: `pc_en`=1, go to FETCH.
- **MEM**
  - `instr_valid`=1, `dmem_req`=1.
  - On `dmem_ack`: `pc_en`=1, go to FETCH.
- **HALT**
  - `halted`=1, `instr_valid`=1.
  - On `resume`: `pc_en`=1, go to FETCH.
- **ERROR**
  - `fetch_err`=1; all requests and `pc_en` are 0.
  - Left only by reset.

Output decoding:
- `imem_req`, `dmem_req`, `instr_valid`, `halted` and `fetch_err` are Moore outputs decoded from the state register.
- `pc_en` is Mealy, asserted in the transition cycle only.

Boundary conditions:
- `imem_ack` outside FETCH and `dmem_ack` outside MEM are ignored.
- `resume` outside HALT is ignored.
- A `resume` already high on entry to HALT is not acted on in the entry cycle. It is acted on from the following cycle.
- `instr_out` holds its value outside FETCH-with-ack.
- A fetch error never asserts `pc_en`, so the PC is frozen at the faulting address.

## Timing
- Reset (`reset`=0, asynchronous):
  - state = FETCH, `instr_out`=0, timer=0.
  - `imem_req`=1 while in reset.
  - All other outputs are 0.
- Minimum latency with acknowledge in the request cycle:
  - non-memory instruction: 2 cycles (FETCH, EXEC);
  - load/store: 3 cycles (FETCH, EXEC, MEM).
- `pc_en` is high in exactly one cycle per retired instruction. The PC updates on that edge, which coincides with re-entry to FETCH.
- Reset asserted mid-access: the state drops to FETCH immediately. The outstanding request is abandoned and `pc_en` is not asserted.

## Configuration
`FETCH_SEQUENCER_TIMEOUT_EN` defined:
- A `$clog2(TIMEOUT_CYCLES)`-bit timer clears on every entry to FETCH or MEM.
- It increments each cycle in those states without an acknowledge.
- If the timer equals `TIMEOUT_CYCLES-1` and there is still no acknowledge, the next state is ERROR.
- An acknowledge in that same cycle wins.

Undefined:
- No timer and no ERROR state; the sequencer waits indefinitely.
- `fetch_err` is tied to 0.

## Structure
- Shared package `rv32_pkg` holds:
  - the `fetch_state_t` enum (FETCH, EXEC, MEM, HALT, ERROR);
  - the `INSTR_EBREAK`/`INSTR_ECALL` constants used by the decoder to drive `halt_instr`.
- One sub-module, `ack_timer` (clear, count enable, terminal flag). It is instantiated only under the macro.

## Test plan
- Reset then release, with `imem_ack`=1 constantly and no flags → `imem_req`=1 at release. `pc_en` pulses every 2nd cycle; 10 instructions take 20 cycles.
- `imem_rdata`=32'h00A00093 acked on cycle 3 of FETCH → `instr_out`=32'h00A00093 the next cycle, `instr_valid`=1, `pc_en` asserted exactly once.
- `dmem_access`=1 in EXEC, `dmem_ack` on the 4th MEM cycle → `dmem_req` high for 4 cycles. `pc_en` is high only in the ack cycle; the next state is FETCH.
- `halt_instr`=1 and `dmem_access`=1 together → HALT, `halted`=1, no `dmem_req`. `resume` pulsed 5 cycles later → `pc_en`=1 that cycle, then FETCH.
- Macro on, `TIMEOUT_CYCLES`=4, no `imem_ack` → ERROR after 4 FETCH cycles. `fetch_err`=1 sticky, `imem_req`=0, `pc_en` never asserted; `reset` low clears it.
- `reset` low during MEM → `dmem_req`=0 immediately, `imem_req`=1, no `pc_en`.
